// File: rtl/coef_reg_bank.sv
// coef_reg_bank: adaptive FIR coefficient register bank.
// Holds NTAPS signed W-bit weights and supports hold, parallel load,
// saturating LMS update (w += delta) and a multi-beat serial load.
// Saturation is reported per tap with sticky flags.
module coef_reg_bank #(
  parameter int NTAPS = 15,
  parameter int W     = 10
) (
  input  logic               clk,
  input  logic               r,
  input  logic               freeze,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         mode,
  input  logic [NTAPS*W-1:0] pdata,
  input  logic [W-1:0]       sdata,
  output logic [NTAPS*W-1:0] w,
  output logic [NTAPS-1:0]   sat,
  output logic               busy,
  output logic               upd_done
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
  localparam logic [W-1:0]  W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  W_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_PLOAD  = 2'b01,
    MODE_UPDATE = 2'b10,
    MODE_SLOAD  = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SLOAD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NTAPS*W-1:0] w_q, w_d;
  logic [NTAPS-1:0]   sat_q, sat_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               accept;

  logic [W-1:0]       upd_val [NTAPS];
  logic [NTAPS-1:0]   upd_ovf;

  assign cmd_ready = ~freeze;
  assign accept    = cmd_valid & ~freeze;

  // Per-tap saturating adder: sum at W+1 bits so overflow shows up as the
  // top two bits disagreeing, then clamp towards the sign of the true sum.
  for (genvar g = 0; g < NTAPS; g++) begin : g_tap
    logic [W:0] sum;
    assign sum        = {w_q[g*W+W-1], w_q[g*W +: W]} + {pdata[g*W+W-1], pdata[g*W +: W]};
    assign upd_ovf[g] = sum[W] ^ sum[W-1];
    assign upd_val[g] = !upd_ovf[g] ? sum[W-1:0] : (sum[W] ? W_MIN : W_MAX);
  end

  // Next-state and next-weight logic; everything holds unless a beat is accepted.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    sat_d   = sat_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (mode)
            MODE_PLOAD: begin
              w_d    = pdata;
              sat_d  = '0;
              done_d = 1'b1;
            end
            MODE_UPDATE: begin
              for (int k = 0; k < NTAPS; k++) begin
                w_d[k*W +: W] = upd_val[k];
              end
              sat_d  = sat_q | upd_ovf;
              done_d = 1'b1;
            end
            MODE_SLOAD: begin
              w_d[0 +: W] = sdata;
              idx_d       = IW'(1);
              state_d     = SLOAD;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end

      SLOAD: begin
        if (accept) begin
          for (int k = 0; k < NTAPS; k++) begin
            if (IW'(k) == idx_q) begin
              w_d[k*W +: W] = sdata;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_d = (state_d == SLOAD);

  // State and datapath registers; reset also wipes any partially loaded taps.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= IDLE;
      w_q     <= '0;
      sat_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      sat_q   <= sat_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign w        = w_q;
  assign sat      = sat_q;
  assign busy     = busy_q;
  assign upd_done = done_q;

endmodule

// File: tb/tb_coef_reg_bank.sv
// tb_coef_reg_bank: directed, table-driven bench for coef_reg_bank.
module tb_coef_reg_bank;

  localparam int NTAPS = 15;
  localparam int W     = 10;

  localparam logic [1:0] M_HOLD   = 2'b00;
  localparam logic [1:0] M_PLOAD  = 2'b01;
  localparam logic [1:0] M_UPDATE = 2'b10;
  localparam logic [1:0] M_SLOAD  = 2'b11;

  logic               clk;
  logic               r;
  logic               freeze;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         mode;
  logic [NTAPS*W-1:0] pdata;
  logic [W-1:0]       sdata;
  logic [NTAPS*W-1:0] w;
  logic [NTAPS-1:0]   sat;
  logic               busy;
  logic               upd_done;

  int checks;
  int errors;

  typedef struct {
    logic               valid;
    logic               frz;
    logic [1:0]         mode;
    logic [NTAPS*W-1:0] pdata;
    logic [NTAPS*W-1:0] exp_w;
    logic [NTAPS-1:0]   exp_sat;
    logic               exp_done;
  } vec_t;

  vec_t vecs[$];

  int a  [NTAPS];
  int dl [NTAPS];
  int ew [NTAPS];
  logic [NTAPS-1:0] esat;

  coef_reg_bank #(.NTAPS(NTAPS), .W(W)) dut (
    .clk       (clk),
    .r         (r),
    .freeze    (freeze),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .mode      (mode),
    .pdata     (pdata),
    .sdata     (sdata),
    .w         (w),
    .sat       (sat),
    .busy      (busy),
    .upd_done  (upd_done)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NTAPS*W-1:0] packTaps(input int v [NTAPS]);
    logic [NTAPS*W-1:0] res;
    res = '0;
    for (int k = 0; k < NTAPS; k++) res[k*W +: W] = W'(v[k]);
    return res;
  endfunction

  task automatic addVec(input logic v, input logic f, input logic [1:0] m,
                        input logic [NTAPS*W-1:0] p, input logic [NTAPS*W-1:0] ex_w,
                        input logic [NTAPS-1:0] ex_s, input logic ex_d);
    vec_t t;
    t.valid = v; t.frz = f; t.mode = m; t.pdata = p;
    t.exp_w = ex_w; t.exp_sat = ex_s; t.exp_done = ex_d;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the active edge.
  task automatic applyStimulus(input logic v, input logic f, input logic [1:0] m,
                               input logic [NTAPS*W-1:0] p, input logic [W-1:0] s);
    cmd_valid = v;
    freeze    = f;
    mode      = m;
    pdata     = p;
    sdata     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [NTAPS*W-1:0] ex_w,
                             input logic [NTAPS-1:0] ex_s, input logic ex_b,
                             input logic ex_d);
    checks++;
    if (w !== ex_w) begin
      errors++;
      $display("[TB] FAIL %s w: got %h expected %h", name, w, ex_w);
    end
    checks++;
    if (sat !== ex_s) begin
      errors++;
      $display("[TB] FAIL %s sat: got %b expected %b", name, sat, ex_s);
    end
    checks++;
    if (busy !== ex_b) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b expected %b", name, busy, ex_b);
    end
    checks++;
    if (upd_done !== ex_d) begin
      errors++;
      $display("[TB] FAIL %s upd_done: got %b expected %b", name, upd_done, ex_d);
    end
    checks++;
    if (cmd_ready !== ~freeze) begin
      errors++;
      $display("[TB] FAIL %s cmd_ready: got %b expected %b", name, cmd_ready, ~freeze);
    end
  endtask

  // Serial-load beat helper: writes tap i of the expected image, then checks.
  task automatic sloadBeat(input string name, input int i, input int val,
                           input logic [1:0] m);
    logic [NTAPS*W-1:0] junk;
    junk = '1;
    applyStimulus(1'b1, 1'b0, m, junk, W'(val));
    ew[i] = val;
    checkOutput($sformatf("%s_beat%0d", name, i), packTaps(ew), esat,
                (i != NTAPS-1), (i == NTAPS-1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    r = 1'b0;
    cmd_valid = 1'b0;
    freeze = 1'b0;
    mode = M_HOLD;
    pdata = '0;
    sdata = '0;

    // ---------------- vector table ----------------
    for (int k = 0; k < NTAPS; k++) begin a[k] = 0; dl[k] = 0; end
    addVec(1, 0, M_HOLD, packTaps(a), '0, '0, 0);
    for (int k = 0; k < NTAPS; k++) a[k] = k + 1;
    addVec(1, 0, M_PLOAD, packTaps(a), packTaps(a), '0, 1);
    for (int k = 0; k < NTAPS; k++) dl[k] = 9;
    addVec(0, 0, M_PLOAD, packTaps(dl), packTaps(a), '0, 0);
    a[0] = 500; a[1] = -510; a[2] = 3;
    addVec(1, 0, M_PLOAD, packTaps(a), packTaps(a), '0, 1);
    for (int k = 0; k < NTAPS; k++) begin dl[k] = 0; ew[k] = a[k]; end
    dl[0] = 20; dl[1] = -5; dl[2] = -7;
    ew[0] = 511; ew[1] = -512; ew[2] = -4;
    addVec(1, 0, M_UPDATE, packTaps(dl), packTaps(ew), 15'b000000000000011, 1);
    for (int k = 0; k < NTAPS; k++) dl[k] = 0;
    dl[0] = 5; dl[1] = -1; dl[2] = 511; dl[3] = -1; dl[4] = 506; dl[5] = -511;
    ew[2] = 507; ew[3] = 3; ew[4] = 511; ew[5] = -505;
    addVec(1, 0, M_UPDATE, packTaps(dl), packTaps(ew), 15'b000000000000011, 1);
    addVec(1, 0, M_HOLD, '1, packTaps(ew), 15'b000000000000011, 0);
    for (int k = 0; k < NTAPS; k++) a[k] = 7;
    addVec(1, 1, M_PLOAD, packTaps(a), packTaps(ew), 15'b000000000000011, 0);
    addVec(1, 0, M_PLOAD, packTaps(a), packTaps(a), '0, 1);
    for (int k = 0; k < NTAPS; k++) begin dl[k] = 0; ew[k] = 7; end
    dl[14] = -512; dl[13] = 511; dl[12] = -8;
    ew[14] = -505; ew[13] = 511; ew[12] = -1;
    addVec(1, 0, M_UPDATE, packTaps(dl), packTaps(ew), 15'b010000000000000, 1);
    for (int k = 0; k < NTAPS; k++) dl[k] = 0;
    dl[12] = -511;
    ew[12] = -512;
    addVec(1, 0, M_UPDATE, packTaps(dl), packTaps(ew), 15'b010000000000000, 1);
    esat = 15'b010000000000000;

    // ---------------- reset at start ----------------
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_init", '0, '0, 1'b0, 1'b0);
    r = 1'b1;

    // ---------------- table-driven single-cycle operations ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].frz, vecs[i].mode, vecs[i].pdata, '0);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].exp_sat, 1'b0,
                  vecs[i].exp_done);
    end

    // ---------------- serial load with idle and freeze gaps ----------------
    for (int i = 0; i < NTAPS; i++) begin
      if (i == 4 || i == 8 || i == 11) begin
        applyStimulus(1'b0, 1'b0, M_SLOAD, '0, W'(0));
        checkOutput($sformatf("sload_idle%0d", i), packTaps(ew), esat, 1'b1, 1'b0);
      end
      if (i == 6 || i == 12) begin
        applyStimulus(1'b1, 1'b1, M_SLOAD, '1, '1);
        checkOutput($sformatf("sload_frz%0d", i), packTaps(ew), esat, 1'b1, 1'b0);
      end
      sloadBeat("sload", i, 100 + i, (i == 0) ? M_SLOAD : 2'(i % 4));
    end
    applyStimulus(1'b0, 1'b0, M_HOLD, '0, '0);
    checkOutput("sload_after", packTaps(ew), esat, 1'b0, 1'b0);

    // ---------------- reset in the middle of a serial load ----------------
    for (int i = 0; i < 7; i++) sloadBeat("abort", i, 200 + i, M_SLOAD);
    cmd_valid = 1'b0;
    #3 r = 1'b0;
    #1;
    checkOutput("reset_mid_sload", '0, '0, 1'b0, 1'b0);
    #2 r = 1'b1;
    for (int k = 0; k < NTAPS; k++) ew[k] = 0;
    esat = '0;
    for (int i = 0; i < NTAPS; i++) sloadBeat("reload", i, i + 1, M_SLOAD);

    // ---------------- freeze holds an UPDATE until released ----------------
    for (int k = 0; k < NTAPS; k++) dl[k] = 0;
    dl[0] = 1; dl[1] = -3;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b1, M_UPDATE, packTaps(dl), '0);
      checkOutput($sformatf("freeze%0d", c), packTaps(ew), '0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, M_UPDATE, packTaps(dl), '0);
    ew[0] = 2; ew[1] = -1;
    checkOutput("freeze_release", packTaps(ew), '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, M_UPDATE, packTaps(dl), '0);
    checkOutput("freeze_after", packTaps(ew), '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
